// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: opcode constants, IF/ID buffer state encoding
// and the IF/ID entry record.
package rv_pkg;

  localparam int unsigned PC_W = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } if_id_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } if_id_entry_t;

endpackage

// File: rtl/imm12_sel.sv
// Selects the raw 12-bit immediate field of an instruction by opcode class.
// B-type yields imm[12:1]; the consumer shifts left after sign extension.
module imm12_sel
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [11:0] o_imm12
);

  logic [6:0] w_opcode;

  assign w_opcode = i_instr[6:0];

  always_comb begin
    o_imm12 = 12'h000;
    case (w_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM:
        o_imm12 = i_instr[31:20];
      OPC_STORE:
        o_imm12 = {i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        o_imm12 = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
      default:
        o_imm12 = 12'h000;
    endcase
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID skid register with flush and field split-out.
// Define IF_ID_STALL_CNT_EN to add the stall_cnt output.
module if_id_skid_reg
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [11:0]     out_imm12
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  if_id_state_e r_state;
  if_id_entry_t r_main;
  if_id_entry_t r_skid;
  if_id_entry_t w_in;
  logic         w_accept;
  logic         w_consume;

  assign w_in.pc    = PC_W'(in_pc);
  assign w_in.instr = in_instr;

  // Both handshake flags depend only on state, so no out_ready -> in_ready path.
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main  <= w_in;
            r_state <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_consume) begin
            r_main <= w_in;
          end else if (w_accept) begin
            r_skid  <= w_in;
            r_state <= FULL;
          end else if (w_consume) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_consume) begin
            r_main  <= r_skid;
            r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_pc     = XLEN'(r_main.pc);
  assign out_instr  = r_main.instr;
  assign out_opcode = r_main.instr[6:0];
  assign out_rd     = r_main.instr[11:7];
  assign out_funct3 = r_main.instr[14:12];
  assign out_rs1    = r_main.instr[19:15];
  assign out_rs2    = r_main.instr[24:20];
  assign out_funct7 = r_main.instr[31:25];

  imm12_sel u_imm12_sel (
    .i_instr (r_main.instr),
    .o_imm12 (out_imm12)
  );

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Flush deliberately does not clear the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (out_valid && !out_ready) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: decode vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_if_id_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic [11:0] out_imm12;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  if_id_skid_reg #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_funct3 (out_funct3),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_funct7 (out_funct7),
    .out_imm12  (out_imm12)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [11:0] imm;
    logic [6:0]  opc;
    logic [4:0]  rd;
  } vec_t;

  ent_t        q[$];
  logic [63:0] done_pc[$];
  logic        acc_last;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Immediate field as defined by opcode class, independent of the DUT.
  function automatic logic [11:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: return i[31:20];
      7'h23: return {i[31:25], i[11:7]};
      7'h63: return {i[31], i[7], i[30:25], i[11:8]};
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_pc", out_pc, q[0].pc);
      chk("out_instr", out_instr, q[0].instr);
      chk("out_imm12", out_imm12, ref_imm(q[0].instr));
      chk("out_fields", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode},
          q[0].instr);
    end
  endtask

  // Check, clock once, then advance the model with the sampled handshake.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                     input logic rdy, input logic fl);
    logic cons;
    logic acc;
    ent_t e;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    check_outputs();
    @(posedge clk);
    if (fl) begin
      q.delete();
      acc_last = 1'b0;
    end else begin
      cons = (q.size() > 0) && rdy;
      acc  = v && (q.size() < 2);
      if (cons) begin
        done_pc.push_back(q[0].pc);
        void'(q.pop_front());
      end
      if (acc) begin
        e.pc    = pc;
        e.instr = ins;
        q.push_back(e);
      end
      acc_last = acc;
    end
    #1;
  endtask

  vec_t vt[7];
  logic [6:0] opcs[9];

  initial begin
    vt[0] = '{instr: 32'h06400093, imm: 12'h064, opc: 7'h13, rd: 5'd1};
    vt[1] = '{instr: 32'hFE112E23, imm: 12'hFFC, opc: 7'h23, rd: 5'h1C};
    vt[2] = '{instr: 32'hFE000EE3, imm: 12'hFFE, opc: 7'h63, rd: 5'h1D};
    vt[3] = '{instr: 32'h123450B7, imm: 12'h000, opc: 7'h37, rd: 5'd1};
    vt[4] = '{instr: 32'h0081A283, imm: 12'h008, opc: 7'h03, rd: 5'd5};
    vt[5] = '{instr: 32'h30529073, imm: 12'h305, opc: 7'h73, rd: 5'd0};
    vt[6] = '{instr: 32'h002081B3, imm: 12'h000, opc: 7'h33, rd: 5'd3};
    opcs  = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h33};

    // Reset: handshakes during reset must be ignored.
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc = 64'h40; in_instr = 32'h06400093;
    out_ready = 1'b0; acc_last = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_fields", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, 32'd0);
    chk("rst_imm12", out_imm12, 12'd0);
    #10;
    rst = 1'b0;
    chk("rst_ignore", out_valid, 1'b0);

    // First instruction: one-cycle latency.
    cyc(1'b1, 64'h0, 32'h06400093, 1'b0, 1'b0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm12", out_imm12, 12'h064);
    chk("addi_rd", out_rd, 5'd1);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Decode table.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 64'h100 + 64'(i * 4), vt[i].instr, 1'b0, 1'b0);
      chk("vec_imm12", out_imm12, vt[i].imm);
      chk("vec_opcode", out_opcode, vt[i].opc);
      chk("vec_rd", out_rd, vt[i].rd);
      cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
    end

    // Stream of 8 with back-pressure from cycle 3.
    begin
      int idx;
      idx = 0;
      done_pc.delete();
      for (int c = 0; c < 60 && done_pc.size() < 8; c++) begin
        cyc(idx < 8, 64'h2000 + 64'(idx * 4), 32'h00000013 | (32'(idx) << 20),
            (c < 3) || (c >= 10), 1'b0);
        if (acc_last) idx++;
        if (c == 8) begin
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_out_pc", out_pc, 64'h2000 + 64'd8);
        end
      end
      chk("stream_count", done_pc.size(), 8);
      for (int k = 0; k < 8 && k < done_pc.size(); k++)
        chk("stream_order", done_pc[k], 64'h2000 + 64'(k * 4));
    end

    // Flush while FULL with a same-cycle input and consume.
    cyc(1'b1, 64'h3000, 32'h00100093, 1'b0, 1'b0);
    cyc(1'b1, 64'h3004, 32'h00200093, 1'b0, 1'b0);
    chk("pre_flush_full", in_ready, 1'b0);
    cyc(1'b1, 64'h3008, 32'h00300093, 1'b1, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    cyc(1'b1, 64'h4000, 32'h00400093, 1'b0, 1'b0);
    cyc(1'b1, 64'h4004, 32'h00500093, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_ready", in_ready, 1'b1);
    q.delete();
    #2;
    rst = 1'b0;
    cyc(1'b1, 64'h5000, 32'h00600093, 1'b0, 1'b0);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_pc", out_pc, 64'h5000);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      logic [63:0] p;
      r      = $urandom();
      r[6:0] = opcs[$urandom_range(0, 8)];
      p      = {32'($urandom()), 32'($urandom())};
      cyc($urandom_range(0, 3) != 0, p, r, $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);
    end
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

`ifdef IF_ID_STALL_CNT_EN
    #3;
    rst = 1'b1;
    #1;
    q.delete();
    chk("cnt_rst", stall_cnt, 32'd0);
    #2;
    rst = 1'b0;
    cyc(1'b1, 64'h6000, 32'h00700093, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    chk("stall_cnt", stall_cnt, 32'd5);
    cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b1);
    chk("stall_cnt_flush", stall_cnt, 32'd5);
    cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
    chk("stall_cnt_idle", stall_cnt, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_skid_reg.md
# if_id_skid_reg

IF/ID pipeline register for the RISC-V core: accepts fetched instructions from the fetch stage over a valid/ready handshake and buffers up to two of them. It presents the head instruction with its fields split out, plus the 12-bit immediate field that the downstream `imm_gen` sign-extends to 64 bits. It absorbs one cycle of downstream back-pressure without losing an instruction, and supports a pipeline flush.

## Interface
- `XLEN`, 64, PC width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all buffered instructions (branch/jump redirect).
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  block can accept; equals (state != FULL).
- `in_pc`  in  XLEN  PC of incoming instruction.
- `in_instr`  in  32  incoming instruction word.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  decode consumes head this cycle.
- `out_pc`  out  XLEN  head PC.
- `out_instr`  out  32  head instruction.
- `out_opcode` / `out_rd` / `out_funct3` / `out_rs1` / `out_rs2` / `out_funct7`  out  7/5/3/5/5/7  `instr[6:0]`, `[11:7]`, `[14:12]`, `[19:15]`, `[24:20]`, `[31:25]` of head.
- `out_imm12`  out  12  immediate field for `imm_gen`.

## Operation
- Two entries: main (drives outputs) and skid.
- States: EMPTY (none valid), ONE (main only), FULL (main + skid).
- Accept = `in_valid & in_ready`; consume = `out_valid & out_ready`.
- EMPTY: accept -> load main, go to ONE.
- ONE:
  - accept only -> load skid, go to FULL.
  - consume only -> go to EMPTY.
  - accept + consume -> load main from input, stay in ONE.
- FULL: `in_ready` = 0.
  - consume -> skid moves to main, go to ONE.
  - no consume -> hold.
- `flush` overrides everything: next state EMPTY, and any same-cycle accept or consume is ignored.
- `out_imm12` is computed combinationally from the main entry's opcode:
  - I-type (0000011, 0010011, 0011011, 1100111, 1110011): `instr[31:20]`.
  - S-type (0100011): `{instr[31:25], instr[11:7]}`.
  - B-type (1100011): `{instr[31], instr[7], instr[30:25], instr[11:8]}`, i.e. imm[12:1]. The consumer shifts left by 1 after sign extension.
  - Any other opcode: 12'h000.
- Field outputs are slices of `out_instr`. They are don't-care when `out_valid` = 0 but must remain stable (no X).

## Timing
- Reset (asynchronous): state EMPTY, `out_valid` = 0, `in_ready` = 1.
- Reset values of data outputs: `out_pc`, `out_instr`, all field outputs and `out_imm12` are 0.
- Handshakes sampled while `rst` is high are ignored.
- Latency: an instruction accepted at edge N appears with `out_valid` = 1 after edge N (cycle N+1) when the block was EMPTY.
- Throughput: one instruction per cycle sustained while `out_ready` = 1.
- `in_ready` depends only on state; no combinational path from `out_ready`.
- Back-pressure: when `out_ready` drops, at most one extra instruction is taken into skid, then `in_ready` falls the following cycle.
- Order is strictly preserved; no duplication and no drop except on `flush`.
- Reset asserted mid-transfer clears both entries immediately.

## Configuration
- `IF_ID_STALL_CNT_EN`:
  - Defined: adds output `stall_cnt` (32-bit). It increments on every cycle with `out_valid & ~out_ready`, wraps 32'hFFFF_FFFF -> 0, is cleared by `rst`, and is not cleared by `flush`.
  - Undefined: port and logic are absent.

## Structure
- Shared package `rv_pkg` holds:
  - opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH);
  - the state encoding (EMPTY/ONE/FULL);
  - an `if_id_entry_t` struct {pc, instr}.
- One sub-module, `imm12_sel`, holds the combinational opcode -> `out_imm12` mux; it is reusable by later decode stages.

## Test plan
- After reset: `out_valid` = 0, `in_ready` = 1, all outputs 0. Then push `addi` 32'h06400093 @ pc 0 -> next cycle `out_valid` = 1, `out_imm12` = 12'h064, `out_rd` = 1.
- Store 32'hFE112E23 (sw x1,-4(x2)) -> `out_imm12` = 12'hFFC; branch 32'hFE000EE3 (beq x0,x0,-4) -> `out_imm12` = 12'hFFE; `lui` 32'h123450B7 -> `out_imm12` = 12'h000.
- Stream of 8 instructions with `out_ready` held 0 from cycle 3 -> skid fills, `in_ready` = 0, `out_pc` holds. Release `out_ready` -> all 8 emerge in order, none lost or duplicated.
- `flush` with FULL state and `in_valid` = 1 in the same cycle -> next cycle `out_valid` = 0, state EMPTY, `in_ready` = 1, and the flushed-cycle input is discarded.
- Assert `rst` asynchronously mid-stream between edges -> `out_valid` drops immediately. After release, the first accepted instruction appears with 1-cycle latency.
- With `IF_ID_STALL_CNT_EN`: hold `out_ready` = 0 for 5 cycles with `out_valid` = 1 -> `stall_cnt` = 5. A following `flush` leaves the count at 5.
